rvv_backend_div_rs: RTL and testbench

Reservation-station FIFO for the vector divide unit. It sits between dispatch and rvv_backend_div. Dispatch pushes up to PUSH_NUM DIV_RS_t uops per cycle. The divide stage sees the oldest `NUM_DIV entries in order and pops any in-order prefix of them. Each entry's readiness to the divide stage is derived from fifo_empty and fifo_almost_empty.

---
 rtl/rvv_backend_div_rs_pkg.sv | 30 +++
 rtl/rvv_backend_div_rs.sv | 109 ++++++++++
 tb/tb_rvv_backend_div_rs.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rvv_backend_div_rs_pkg.sv
// Shared types and helpers for the vector divide reservation station.
// The prefix-count helper is reused by the other RS FIFOs.
package rvv_backend_div_rs_pkg;

  localparam int NUM_DIV      = 2;
  localparam int DIV_RS_DEPTH = 8;
  localparam int RS_MAX_PORTS = 8;

  typedef struct packed {
    logic [3:0]  uop_index;
    logic [4:0]  vd_addr;
    logic [31:0] src1;
    logic [31:0] src2;
  } DIV_RS_t;

  // Length of the run of ones starting at bit 0. For a legal in-order
  // valid vector this equals its popcount.
  function automatic int unsigned rs_prefix_count(input logic [RS_MAX_PORTS-1:0] vld);
    int unsigned n;
    logic        run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < RS_MAX_PORTS; i++) begin
      run = run & vld[i];
      if (run) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/rvv_backend_div_rs.sv
// Reservation-station FIFO between dispatch and the vector divide unit.
// Multi-port in-order push/pop; all status flags come from the registered count.
module rvv_backend_div_rs
  import rvv_backend_div_rs_pkg::*;
#(
  parameter int DEPTH     = DIV_RS_DEPTH,
  parameter int PUSH_NUM  = 2,
  parameter int POP_NUM   = NUM_DIV,
  parameter bit ASSERT_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         trap_flush_rvv,
  input  logic [PUSH_NUM-1:0]          push,
  input  DIV_RS_t [PUSH_NUM-1:0]       push_data,
  output logic                         fifo_full,
  output logic [PUSH_NUM-1:1]          fifo_almost_full,
  input  logic [POP_NUM-1:0]           pop,
  output DIV_RS_t [POP_NUM-1:0]        pop_data,
  output logic                         fifo_empty,
  output logic [POP_NUM-1:1]           fifo_almost_empty,
  output logic [$clog2(DEPTH):0]       remain
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  DIV_RS_t       r_mem [DEPTH];

  logic [CW-1:0] w_free;
  logic [CW-1:0] w_pushReq;
  logic [CW-1:0] w_popReq;
  logic [CW-1:0] w_npush;
  logic [CW-1:0] w_npop;

  // Requests beyond the free space or the occupancy are silently trimmed.
  always_comb begin
    w_free    = CW'(DEPTH) - r_count;
    w_pushReq = CW'(rs_prefix_count(RS_MAX_PORTS'(push)));
    w_popReq  = CW'(rs_prefix_count(RS_MAX_PORTS'(pop)));
    w_npush   = (w_pushReq > w_free) ? w_free : w_pushReq;
    w_npop    = (w_popReq > r_count) ? r_count : w_popReq;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (trap_flush_rvv) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      r_wrPtr <= r_wrPtr + PW'(w_npush);
      r_rdPtr <= r_rdPtr + PW'(w_npop);
      r_count <= r_count + w_npush - w_npop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (!trap_flush_rvv) begin
      for (int i = 0; i < PUSH_NUM; i++) begin
        if (CW'(i) < w_npush) r_mem[r_wrPtr + PW'(i)] <= push_data[i];
      end
    end
  end

  assign fifo_full  = (r_count == CW'(DEPTH));
  assign fifo_empty = (r_count == '0);
  assign remain     = r_count;

  for (genvar i = 1; i < PUSH_NUM; i++) begin : g_almostFull
    assign fifo_almost_full[i] = (w_free <= CW'(i));
  end

  for (genvar i = 1; i < POP_NUM; i++) begin : g_almostEmpty
    assign fifo_almost_empty[i] = (r_count <= CW'(i));
  end

  for (genvar i = 0; i < POP_NUM; i++) begin : g_popData
    assign pop_data[i] = r_mem[r_rdPtr + PW'(i)];
  end

  // Legality of dispatch and divide-stage requests.
  for (genvar i = 0; i < PUSH_NUM; i++) begin : g_pushSva
    a_pushRoom: assert property (@(posedge clk) disable iff (!rst_n || !ASSERT_EN)
      push[i] |-> (w_free > CW'(i)));
    if (i > 0) begin : g_prefix
      a_pushPrefix: assert property (@(posedge clk) disable iff (!rst_n || !ASSERT_EN)
        push[i] |-> push[i-1]);
    end
  end

  for (genvar i = 0; i < POP_NUM; i++) begin : g_popSva
    a_popAvail: assert property (@(posedge clk) disable iff (!rst_n || !ASSERT_EN)
      pop[i] |-> (r_count > CW'(i)));
    if (i > 0) begin : g_prefix
      a_popPrefix: assert property (@(posedge clk) disable iff (!rst_n || !ASSERT_EN)
        pop[i] |-> pop[i-1]);
    end
  end

endmodule

// File: tb/tb_rvv_backend_div_rs.sv
// Directed bench for the divide reservation station with a queue scoreboard
// holding the expected FIFO contents and modelled pointers.
module tb_rvv_backend_div_rs;
  import rvv_backend_div_rs_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                trap_flush_rvv;
  logic [1:0]          push;
  DIV_RS_t [1:0]       push_data;
  logic                fifo_full;
  logic [1:1]          fifo_almost_full;
  logic [1:0]          pop;
  DIV_RS_t [1:0]       pop_data;
  logic                fifo_empty;
  logic [1:1]          fifo_almost_empty;
  logic [3:0]          remain;

  int checks = 0;
  int errors = 0;

  DIV_RS_t expQ[$];
  int      mWr = 0;
  int      mRd = 0;

  // Legality assertions are off so that excess push/pop trimming can be exercised.
  rvv_backend_div_rs #(
    .DEPTH(8), .PUSH_NUM(2), .POP_NUM(2), .ASSERT_EN(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trap_flush_rvv(trap_flush_rvv),
    .push(push), .push_data(push_data),
    .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
    .pop(pop), .pop_data(pop_data),
    .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .remain(remain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic DIV_RS_t randUop();
    DIV_RS_t d;
    d.uop_index = 4'($urandom);
    d.vd_addr   = 5'($urandom);
    d.src1      = $urandom;
    d.src2      = $urandom;
    return d;
  endfunction

  // Compares every status output and the visible entries against the model.
  task automatic checkOutput(input string tag);
    int n;
    n = expQ.size();
    checkValue({tag, ".remain"}, 128'(remain), 128'(n));
    checkValue({tag, ".empty"}, 128'(fifo_empty), 128'(n == 0));
    checkValue({tag, ".full"}, 128'(fifo_full), 128'(n == 8));
    checkValue({tag, ".almostEmpty1"}, 128'(fifo_almost_empty[1]), 128'(n <= 1));
    checkValue({tag, ".almostFull1"}, 128'(fifo_almost_full[1]), 128'((8 - n) <= 1));
    checkValue({tag, ".wrPtr"}, 128'(dut.r_wrPtr), 128'(mWr % 8));
    checkValue({tag, ".rdPtr"}, 128'(dut.r_rdPtr), 128'(mRd % 8));
    for (int i = 0; i < 2; i++) begin
      if (i < n) checkValue($sformatf("%s.popData%0d", tag, i), 128'(pop_data[i]), 128'(expQ[i]));
    end
  endtask

  // Called just after a falling edge; drives one cycle of requests and
  // returns at the next falling edge with the model updated.
  task automatic applyStimulus(input string tag, input logic [1:0] pushV,
                               input logic [1:0] popV, input logic flushV);
    int nPushReq, nPopReq, nPush, nPop, n;
    DIV_RS_t d0, d1;
    d0 = randUop();
    d1 = randUop();
    push           = pushV;
    push_data      = {d1, d0};
    pop            = popV;
    trap_flush_rvv = flushV;
    n        = expQ.size();
    nPushReq = pushV[0] ? (pushV[1] ? 2 : 1) : 0;
    nPopReq  = popV[0] ? (popV[1] ? 2 : 1) : 0;
    nPush    = (nPushReq > 8 - n) ? 8 - n : nPushReq;
    nPop     = (nPopReq > n) ? n : nPopReq;
    for (int i = 0; i < nPop; i++)
      checkValue($sformatf("%s.popped%0d", tag, i), 128'(pop_data[i]), 128'(expQ[i]));
    if (flushV) begin
      expQ.delete();
      mWr = 0;
      mRd = 0;
    end else begin
      for (int i = 0; i < nPop; i++) void'(expQ.pop_front());
      if (nPush > 0) expQ.push_back(d0);
      if (nPush > 1) expQ.push_back(d1);
      mWr = (mWr + nPush) % 8;
      mRd = (mRd + nPop) % 8;
    end
    @(posedge clk);
    #1;
    push           = 2'b00;
    pop            = 2'b00;
    trap_flush_rvv = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    trap_flush_rvv = 1'b0;
    push           = 2'b00;
    pop            = 2'b00;
    push_data      = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset");
    checkValue("reset.popData0", 128'(pop_data[0]), 128'(0));
    checkValue("reset.popData1", 128'(pop_data[1]), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus("pushAB", 2'b11, 2'b00, 1'b0);
    checkOutput("pushAB");
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("fill%0d", i), 2'b11, 2'b00, 1'b0);
      checkOutput($sformatf("fill%0d", i));
    end
    applyStimulus("pushWhenFull", 2'b11, 2'b00, 1'b0);
    checkOutput("pushWhenFull");

    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("drain%0d", i), 2'b00, 2'b11, 1'b0);
      checkOutput($sformatf("drain%0d", i));
    end
    applyStimulus("refill0", 2'b11, 2'b00, 1'b0);
    applyStimulus("refill1", 2'b11, 2'b00, 1'b0);
    applyStimulus("refill2", 2'b01, 2'b00, 1'b0);
    checkOutput("at7");
    applyStimulus("wrapPopPush", 2'b01, 2'b11, 1'b0);
    checkOutput("wrapPopPush");

    applyStimulus("down0", 2'b00, 2'b11, 1'b0);
    applyStimulus("down1", 2'b00, 2'b11, 1'b0);
    applyStimulus("down2", 2'b00, 2'b01, 1'b0);
    checkOutput("single");
    applyStimulus("singlePushPop", 2'b01, 2'b01, 1'b0);
    checkOutput("singlePushPop");
    applyStimulus("overPop", 2'b00, 2'b11, 1'b0);
    checkOutput("overPop");
    applyStimulus("popWhenEmpty", 2'b00, 2'b01, 1'b0);
    checkOutput("popWhenEmpty");

    applyStimulus("five0", 2'b11, 2'b00, 1'b0);
    applyStimulus("five1", 2'b11, 2'b00, 1'b0);
    applyStimulus("five2", 2'b01, 2'b00, 1'b0);
    checkOutput("five");
    applyStimulus("flushPush", 2'b11, 2'b00, 1'b1);
    checkOutput("flushPush");

    applyStimulus("four0", 2'b11, 2'b00, 1'b0);
    applyStimulus("four1", 2'b11, 2'b00, 1'b0);
    checkOutput("four");
    #2;
    rst_n = 1'b0;
    #1;
    expQ.delete();
    mWr = 0;
    mRd = 0;
    checkOutput("asyncReset");
    checkValue("asyncReset.popData0", 128'(pop_data[0]), 128'(0));
    checkValue("asyncReset.popData1", 128'(pop_data[1]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus("afterReset", 2'b11, 2'b00, 1'b0);
    checkOutput("afterReset");
    applyStimulus("afterResetPop", 2'b00, 2'b11, 1'b0);
    checkOutput("afterResetPop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
